shared_mem_ctrl: RTL and testbench
==================================

# shared_mem_ctrl

Shared-memory responder on the far side of the three-CPU memory arbiter. It samples the arbiter's 2-bit `grant`, latches the granted CPU's request, and performs one single-port RAM access with a configurable number of wait states. It then returns a one-cycle acknowledge to that CPU. The arbiter decides who may access memory; this block executes the access.

## Interface
- `ADDR_W`, 8, word-address width; RAM depth is 2**ADDR_W words.
- `DATA_W`, 16, data word width.
- `WAIT_STATES`, 2, wait cycles per access; legal range 0..7.

- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `grant`  in  2  arbiter grant: 00 none, 01 CPU1, 10 CPU2, 11 CPU3.
- `cpu_we`  in  3  per-CPU write enable; bit i = CPU(i+1).
- `cpu_addr`  in  3*ADDR_W  per-CPU address; slice i = CPU(i+1).
- `cpu_wdata`  in  3*DATA_W  per-CPU write data; slice i = CPU(i+1).
- `cpu_ack`  out  3  one-cycle completion strobe to the owning CPU.
- `rdata`  out  DATA_W  read data; valid in the ACK cycle of a read.
- `owner`  out  2  grant code of the transaction in flight; 00 when idle.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- FSM states: IDLE, WAIT, ACK.
- IDLE:
  - If `grant` is 00, stay in IDLE.
  - Otherwise latch `owner`=`grant`, plus that CPU's `we`, `addr` and `wdata`.
  - If WAIT_STATES>0: go to WAIT with the counter at WAIT_STATES-1.
  - If WAIT_STATES=0: perform the access on this edge and go to ACK.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter is 0: perform the access on that edge and go to ACK.
- Access:
  - Write: `mem[addr]` <= latched wdata.
  - Read: `rdata` <= `mem[addr]`.
  - Exactly one RAM operation per transaction.
- ACK: `cpu_ack[owner-1]`=1 for exactly one cycle, all other ack bits 0, then unconditionally go to IDLE.
- The IDLE turnaround cycle after ACK lets the arbiter's registered grant update after the CPU drops its request.
- `grant` changes during WAIT or ACK are ignored. The latched owner always completes its transaction.
- Input changes on `cpu_*` after latching have no effect.
- `rdata` holds the last read value until the next read completes. Writes never modify `rdata`.
- RAM contents are not reset. Reads of never-written addresses return X in simulation, which is acceptable.
- Address arithmetic: none. The address is used directly, width ADDR_W, with no wrap logic.

## Timing
- Reset (asynchronous assert, synchronous deassert by the system): state=IDLE, `cpu_ack`=000, `rdata`=0, `owner`=00, `busy`=0, counter=0.
- Reset asserted mid-transaction aborts it:
  - a pending write is not committed;
  - no ack is issued;
  - RAM contents are preserved.
- Cycle numbering: `grant` sampled non-zero at edge 0, and cycle k is the cycle after edge k-1.
  - `busy`=1 in cycles 1..WAIT_STATES+1.
  - `cpu_ack` is high in cycle WAIT_STATES+1 only.
  - On reads, `rdata` is valid from cycle WAIT_STATES+1.
- Minimum spacing between transactions: WAIT_STATES+2 cycles (one mandatory IDLE cycle).
- `owner` is valid in cycles 1..WAIT_STATES+1.

## Structure
- Package `shared_mem_pkg` holds:
  - grant code constants GNT_NONE=2'b00, GNT1=2'b01, GNT2=2'b10, GNT3=2'b11, matching the arbiter's encoding;
  - the FSM state encoding IDLE/WAIT/ACK;
  - the WAIT_STATES legal-range limit.
- Sub-module `sp_ram`: synchronous single-port RAM (clk, we, addr, wdata, rdata, parameters ADDR_W/DATA_W), no reset on the array.
- `shared_mem_ctrl` contains the FSM, wait counter, request latch/mux and ack decode.

## Test plan
- Reset: hold `reset_n`=0 with `grant`=01 -> `cpu_ack`=000, `rdata`=0, `owner`=00, `busy`=0. Outputs clear immediately on assertion, without waiting for a clock edge.
- Write, WAIT_STATES=2: `grant`=01, `cpu_we[0]`=1, CPU1 addr=0x10, wdata=0xBEEF -> `busy` high in cycles 1-3, `owner`=01, `cpu_ack`=001 in cycle 3 only.
- Read-back: after the IDLE cycle, `grant`=10, CPU2 addr=0x10, we=0 -> `cpu_ack`=010 in cycle 3, `rdata`=0xBEEF.
- Grant change mid-transaction: CPU1 read starts, `grant` switches to 11 in cycle 1 -> ack goes to CPU1 only (001) and `owner` stays 01. CPU3's transaction starts from the following IDLE, and its ack arrives in the expected cycle.
- Abort: `reset_n` pulsed low during WAIT of a CPU3 write of 0x1234 to 0x10 -> no ack, all outputs at reset values. A later read of 0x10 returns 0xBEEF.
- Zero wait, WAIT_STATES=0: grant held at 01 with continuous requests -> ack in cycle 1, then every 2 cycles (001 in cycles 1, 3, 5), `busy` toggling.

Source files
------------

// File: rtl/shared_mem_pkg.sv
// Shared-memory controller types: grant codes, FSM states,
// wait-state limit and the ack decode helper.
package shared_mem_pkg;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT1     = 2'b01;
  localparam logic [1:0] GNT2     = 2'b10;
  localparam logic [1:0] GNT3     = 2'b11;

  localparam int WAIT_MAX = 7;
  localparam int CNT_W    = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_ACK  = 2'b10
  } state_t;

  function automatic logic [2:0] ack_onehot(input logic [1:0] g);
    logic [2:0] a;
    a = 3'b000;
    unique case (1'b1)
      (g == GNT1): a = 3'b001;
      (g == GNT2): a = 3'b010;
      (g == GNT3): a = 3'b100;
      default:     a = 3'b000;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/shared_mem_ctrl_sp_ram.sv
// Synchronous single-port RAM; read data is registered
// and only changes on an enabled read.
module sp_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/shared_mem_ctrl.sv
// Shared-memory responder: latches the granted CPU request,
// runs one RAM access after the wait states, then acks.
module shared_mem_ctrl
  import shared_mem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int WAIT_STATES = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          grant,
  input  logic [2:0]          cpu_we,
  input  logic [3*ADDR_W-1:0] cpu_addr,
  input  logic [3*DATA_W-1:0] cpu_wdata,
  output logic [2:0]          cpu_ack,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          owner,
  output logic                busy
);

  localparam int WS =
    (WAIT_STATES > WAIT_MAX) ? WAIT_MAX : WAIT_STATES;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rd_seen;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic              idle;
  logic              acc;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [1:0]        ram_own;

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    unique case (1'b1)
      (grant == GNT1): begin
        sel_we    = cpu_we[0];
        sel_addr  = cpu_addr[0 +: ADDR_W];
        sel_wdata = cpu_wdata[0 +: DATA_W];
      end
      (grant == GNT2): begin
        sel_we    = cpu_we[1];
        sel_addr  = cpu_addr[ADDR_W +: ADDR_W];
        sel_wdata = cpu_wdata[DATA_W +: DATA_W];
      end
      (grant == GNT3): begin
        sel_we    = cpu_we[2];
        sel_addr  = cpu_addr[2*ADDR_W +: ADDR_W];
        sel_wdata = cpu_wdata[2*DATA_W +: DATA_W];
      end
      default: ;
    endcase
  end

  // Zero-wait accesses use the live request; otherwise the latch.
  assign idle      = (state == S_IDLE);
  assign ram_we    = idle ? sel_we    : we_q;
  assign ram_addr  = idle ? sel_addr  : addr_q;
  assign ram_wdata = idle ? sel_wdata : wdata_q;
  assign ram_own   = idle ? grant     : owner;
  assign acc = idle ? ((grant != GNT_NONE) && (WS == 0))
                    : ((state == S_WAIT) && (cnt == '0));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      owner   <= GNT_NONE;
      busy    <= 1'b0;
      cpu_ack <= 3'b000;
      rd_seen <= 1'b0;
    end else begin
      cpu_ack <= 3'b000;
      unique case (state)
        S_IDLE: begin
          if (grant != GNT_NONE) begin
            owner   <= grant;
            we_q    <= sel_we;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            busy    <= 1'b1;
            if (WS != 0) begin
              state <= S_WAIT;
              cnt   <= CNT_W'(WS - 1);
            end
          end
        end
        S_WAIT: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        S_ACK: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          owner <= GNT_NONE;
        end
        default: state <= S_IDLE;
      endcase
      if (acc) begin
        state   <= S_ACK;
        cpu_ack <= ack_onehot(ram_own);
        if (!ram_we) rd_seen <= 1'b1;
      end
    end
  end

  // Read data reads as zero until the first read after reset.
  assign rdata = rd_seen ? ram_rdata : '0;

  sp_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk  (clk),
    .en   (acc),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_shared_mem_ctrl.sv
// Bench for shared_mem_ctrl: scoreboarded random traffic on a
// two-wait-state instance, plus a zero-wait instance.
module tb_shared_mem_ctrl;

  localparam int WA = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;

  logic [1:0]  grant = '0;
  logic [2:0]  cpu_we = '0;
  logic [23:0] cpu_addr = '0;
  logic [47:0] cpu_wdata = '0;
  logic [2:0]  cpu_ack;
  logic [15:0] rdata;
  logic [1:0]  owner;
  logic        busy;

  logic [1:0]  gb = '0;
  logic [2:0]  web = '0;
  logic [23:0] addrb = '0;
  logic [47:0] wdatab = '0;
  logic [2:0]  ackb;
  logic [15:0] rdatab;
  logic [1:0]  ownerb;
  logic        busyb;

  shared_mem_ctrl #(.ADDR_W(8), .DATA_W(16), .WAIT_STATES(WA)) dut (
    .clk(clk), .reset_n(reset_n), .grant(grant), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
    .rdata(rdata), .owner(owner), .busy(busy)
  );

  shared_mem_ctrl #(.ADDR_W(8), .DATA_W(16), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .grant(gb), .cpu_we(web),
    .cpu_addr(addrb), .cpu_wdata(wdatab), .cpu_ack(ackb),
    .rdata(rdatab), .owner(ownerb), .busy(busyb)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         s;
    int         e;
    logic [1:0] g;
    bit         rd;
    logic [15:0] v;
    bit         known;
  } item_t;

  item_t       q[$];
  logic [15:0] mdl[256];
  bit          mval[256];
  logic [15:0] exp_rd = '0;
  bit          exp_known = 1'b0;
  bit          mon_off = 1'b1;
  int          ncyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h",
               nm, ncyc, act, exp);
    end
  endtask

  // Monitor: cycle-exact comparison against the scoreboard head.
  always @(negedge clk) begin
    ncyc++;
    if (!mon_off) begin
      if (q.size() > 0 && ncyc >= q[0].s) begin
        chk("busy", 32'(busy), 32'd1);
        chk("owner", 32'(owner), 32'(q[0].g));
        if (ncyc == q[0].e) begin
          chk("ack", 32'(cpu_ack), 32'(3'b001 << (q[0].g - 1)));
          if (q[0].rd) begin
            exp_rd = q[0].v;
            exp_known = q[0].known;
          end
          void'(q.pop_front());
        end else begin
          chk("ack_early", 32'(cpu_ack), 32'd0);
        end
      end else begin
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_owner", 32'(owner), 32'd0);
        chk("idle_ack", 32'(cpu_ack), 32'd0);
      end
      if (exp_known) chk("rdata", 32'(rdata), 32'(exp_rd));
    end
  end

  task automatic scramble();
    cpu_we = 3'($urandom());
    cpu_addr = 24'($urandom());
    cpu_wdata = 48'({$urandom(), $urandom()});
  endtask

  // Called at negedge+1; leaves the bench at the first legal
  // issue point for the next transaction with grant cleared.
  task automatic issue(input logic [1:0] g, input logic we,
                       input logic [7:0] a, input logic [15:0] d,
                       input int junk);
    item_t it;
    int i;
    i = int'(g) - 1;
    scramble();
    grant = g;
    cpu_we[i] = we;
    cpu_addr[i*8 +: 8] = a;
    cpu_wdata[i*16 +: 16] = d;
    it.s = ncyc + 1;
    it.e = ncyc + WA + 1;
    it.g = g;
    it.rd = !we;
    if (we) begin
      mdl[a] = d;
      mval[a] = 1'b1;
    end
    it.v = mdl[a];
    it.known = mval[a];
    q.push_back(it);
    for (int k = 1; k <= WA + 1; k++) begin
      @(negedge clk); #1;
      grant = (junk < 0) ? 2'($urandom_range(0, 3)) : 2'(junk);
      scramble();
    end
    @(negedge clk); #1;
    grant = '0;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_ack"}, 32'(cpu_ack), 32'd0);
    chk({nm, "_rdata"}, 32'(rdata), 32'd0);
    chk({nm, "_owner"}, 32'(owner), 32'd0);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_ack0"}, 32'(ackb), 32'd0);
    chk({nm, "_busy0"}, 32'(busyb), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mval[i] = 1'b0;
    grant = 2'b01;
    gb = 2'b01;
    #2 reset_n = 1'b0;
    #1 chk_reset("rst_async");
    repeat (3) @(negedge clk);
    #1 chk_reset("rst_hold");
    gb = '0;
    grant = '0;
    reset_n = 1'b1;
    exp_rd = '0;
    exp_known = 1'b1;
    mon_off = 1'b0;

    issue(2'b01, 1'b1, 8'h10, 16'hBEEF, -1);
    issue(2'b10, 1'b0, 8'h10, 16'h0000, -1);
    issue(2'b01, 1'b0, 8'h10, 16'h0000, 3);
    issue(2'b11, 1'b1, 8'h20, 16'h5A5A, -1);
    issue(2'b11, 1'b0, 8'h20, 16'h0000, -1);

    // Abort a CPU3 write in its last wait cycle.
    @(negedge clk); #1;
    mon_off = 1'b1;
    scramble();
    grant = 2'b11;
    cpu_we[2] = 1'b1;
    cpu_addr[16 +: 8] = 8'h10;
    cpu_wdata[32 +: 16] = 16'h1234;
    @(negedge clk); #1;
    grant = '0;
    chk("abort_busy_pre", 32'(busy), 32'd1);
    @(negedge clk); #1;
    reset_n = 1'b0;
    #1 chk_reset("abort");
    @(negedge clk); #1;
    chk_reset("abort_hold");
    reset_n = 1'b1;
    exp_rd = '0;
    exp_known = 1'b1;
    mon_off = 1'b0;
    issue(2'b10, 1'b0, 8'h10, 16'h0000, -1);

    for (int n = 0; n < 40; n++) begin
      issue(2'($urandom_range(1, 3)), 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 15)), 16'($urandom()), -1);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk); #1;
      end
    end
    repeat (4) @(negedge clk);
    #1 chk("sb_empty", 32'(q.size()), 32'd0);

    // Zero wait: grant held, write then back-to-back reads.
    gb = 2'b01;
    web = 3'b001;
    addrb[7:0] = 8'h05;
    wdatab[15:0] = 16'hA5A5;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk); #1;
      chk("zw_ack", 32'(ackb), (k % 2 == 1) ? 32'd1 : 32'd0);
      chk("zw_busy", 32'(busyb), (k % 2 == 1) ? 32'd1 : 32'd0);
      chk("zw_owner", 32'(ownerb), (k % 2 == 1) ? 32'd1 : 32'd0);
      chk("zw_rdata", 32'(rdatab), (k >= 3) ? 32'hA5A5 : 32'd0);
      web = 3'b000;
    end
    gb = '0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
